// File: rtl/sockit_spi_pkg.sv
// Shared helpers for the SPI master buffers.
// Counter/pointer sizing and wrapping pointer increment.
package sockit_spi_pkg;

   // occupancy counter width able to hold 0..depth
   function automatic int sockit_spi_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // pointer width able to hold 0..depth-1
   function automatic int sockit_spi_ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   // increment with explicit wrap at depth-1 (depth need not be 2^n)
   function automatic int sockit_spi_ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sockit_spi_fifo_ptr.sv
// Wrapping pointer counter for sockit_spi_fifo.
// Counts 0..DEPTH-1 and wraps by compare.
module sockit_spi_fifo_ptr
   import sockit_spi_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = sockit_spi_ptr_w(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   // pointer register: reset/clear to zero, else advance on inc
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= PW'(sockit_spi_ptr_inc(int'(ptr), DEPTH));
      end
   end

endmodule

// File: rtl/sockit_spi_fifo.sv
// Valid/ready buffer with occupancy and flush for the SPI master.
// Optional zero-latency bypass: SOCKIT_SPI_FIFO_BYPASS_EN.
module sockit_spi_fifo
   import sockit_spi_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int CW    = sockit_spi_cnt_w(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          i_vld,
   input  logic [DW-1:0] i_dat,
   output logic          i_rdy,
   output logic          o_vld,
   output logic [DW-1:0] o_dat,
   input  logic          o_rdy,
   output logic [CW-1:0] cnt,
   output logic          ful,
   output logic          emp
);

   localparam int PW = sockit_spi_ptr_w(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic          act;
   logic          byp;
   logic          wr;
   logic          rd;

   assign act   = rst & ~clr;
   assign ful   = (cnt == CW'(DEPTH));
   assign emp   = (cnt == '0);
   assign i_rdy = act & ~ful;

   // handshake decode, output select and store/fetch enables
   always_comb begin
      byp   = 1'b0;
      o_vld = act & ~emp;
      o_dat = mem[rp];
`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
      byp = act & emp & i_vld;
      if (byp) begin
         o_vld = 1'b1;
         o_dat = i_dat;
      end
`endif
      // a word that passes straight through is never stored
      wr = i_vld & i_rdy & ~(byp & o_rdy);
      rd = act & ~emp & o_rdy;
   end

   sockit_spi_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (wr),
      .ptr (wp)
   );

   sockit_spi_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rp (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (rd),
      .ptr (rp)
   );

   // storage write; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wp] <= i_dat;
      end
   end

   // occupancy: +1 push only, -1 pop only
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt <= '0;
      end else begin
         case ({wr, rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sockit_spi_fifo.sv
// Directed self-checking bench for sockit_spi_fifo.
// DW=32, DEPTH=4; follows SOCKIT_SPI_FIFO_BYPASS_EN if defined.
module tb_sockit_spi_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        i_vld;
   logic [31:0] i_dat;
   logic        i_rdy;
   logic        o_vld;
   logic [31:0] o_dat;
   logic        o_rdy;
   logic [2:0]  cnt;
   logic        ful;
   logic        emp;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   sockit_spi_fifo #(.DW(32), .DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .i_vld (i_vld),
      .i_dat (i_dat),
      .i_rdy (i_rdy),
      .o_vld (o_vld),
      .o_dat (o_dat),
      .o_rdy (o_rdy),
      .cnt   (cnt),
      .ful   (ful),
      .emp   (emp)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b0;
      clr   = 1'b0;
      i_vld = 1'b0;
      i_dat = '0;
      o_rdy = 1'b0;

      // 1. reset for 3 cycles
      repeat (3) tick();
      chk("rst_irdy", 32'(i_rdy), 32'd0);
      chk("rst_ovld", 32'(o_vld), 32'd0);
      chk("rst_cnt",  32'(cnt),   32'd0);
      chk("rst_emp",  32'(emp),   32'd1);
      chk("rst_ful",  32'(ful),   32'd0);
      rst = 1'b1;
      tick();
      chk("rel_irdy", 32'(i_rdy), 32'd1);
      chk("rel_ovld", 32'(o_vld), 32'd0);

      // 2. fill with o_rdy low
      for (int k = 1; k <= 4; k++) begin
         i_vld = 1'b1;
         i_dat = 32'h11 * k;
         tick();
      end
      i_vld = 1'b0;
      chk("fill_cnt",  32'(cnt),   32'd4);
      chk("fill_ful",  32'(ful),   32'd1);
      chk("fill_irdy", 32'(i_rdy), 32'd0);
      chk("fill_ovld", 32'(o_vld), 32'd1);

      // 3. full boundary: push attempt plus pop
      i_vld = 1'b1;
      i_dat = 32'h55;
      o_rdy = 1'b1;
      #1;
      chk("bnd_odat", o_dat, 32'h11);
      tick();
      i_vld = 1'b0;
      o_rdy = 1'b0;
      chk("bnd_cnt",  32'(cnt),   32'd3);
      chk("bnd_irdy", 32'(i_rdy), 32'd1);

      // drain remaining in order
      o_rdy = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         #1;
         chk("drn_ovld", 32'(o_vld), 32'd1);
         chk("drn_odat", o_dat, 32'h11 * k);
         tick();
      end
      o_rdy = 1'b0;
      chk("drn_emp",  32'(emp),   32'd1);
      chk("drn_cnt",  32'(cnt),   32'd0);
      chk("drn_ovld0", 32'(o_vld), 32'd0);

      // 4. streaming across wrap at cnt=2
      for (int k = 0; k < 2; k++) begin
         i_vld = 1'b1;
         i_dat = 32'h100 + k;
         tick();
      end
      chk("st_cnt0", 32'(cnt), 32'd2);
      for (int k = 0; k < 10; k++) begin
         i_vld = 1'b1;
         i_dat = k;
         o_rdy = 1'b1;
         #1;
         chk("st_ovld", 32'(o_vld), 32'd1);
         chk("st_odat", o_dat, (k < 2) ? 32'h100 + k : 32'(k - 2));
         tick();
         chk("st_cnt", 32'(cnt), 32'd2);
      end
      i_vld = 1'b0;
      o_rdy = 1'b0;
      #1;
      chk("st_tail", o_dat, 32'h8);

      // 5. clear at cnt=3 with push and pop requested
      i_vld = 1'b1;
      i_dat = 32'hC;
      tick();
      chk("clr_pre", 32'(cnt), 32'd3);
      clr   = 1'b1;
      i_dat = 32'hDD;
      o_rdy = 1'b1;
      #1;
      chk("clr_ovld", 32'(o_vld), 32'd0);
      chk("clr_irdy", 32'(i_rdy), 32'd0);
      tick();
      clr   = 1'b0;
      i_vld = 1'b0;
      o_rdy = 1'b0;
      chk("clr_cnt", 32'(cnt), 32'd0);
      chk("clr_emp", 32'(emp), 32'd1);
      chk("clr_ov2", 32'(o_vld), 32'd0);
      i_vld = 1'b1;
      i_dat = 32'hAA;
      tick();
      i_vld = 1'b0;
      chk("aa_ovld", 32'(o_vld), 32'd1);
      chk("aa_odat", o_dat, 32'hAA);
      chk("aa_cnt",  32'(cnt), 32'd1);
      o_rdy = 1'b1;
      tick();
      o_rdy = 1'b0;
      chk("aa_emp", 32'(emp), 32'd1);

      // 6. empty FIFO, word offered with o_rdy high
      i_vld = 1'b1;
      i_dat = 32'h5A;
      o_rdy = 1'b1;
      #1;
`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
      chk("byp_ovld", 32'(o_vld), 32'd1);
      chk("byp_odat", o_dat, 32'h5A);
      tick();
      i_vld = 1'b0;
      chk("byp_cnt", 32'(cnt), 32'd0);
      #1;
      chk("byp_ovld0", 32'(o_vld), 32'd0);
`else
      chk("lat_ovld0", 32'(o_vld), 32'd0);
      tick();
      i_vld = 1'b0;
      chk("lat_ovld", 32'(o_vld), 32'd1);
      chk("lat_odat", o_dat, 32'h5A);
      chk("lat_cnt",  32'(cnt), 32'd1);
      tick();
      chk("lat_emp", 32'(emp), 32'd1);
`endif
      o_rdy = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
